// File: rtl/checkpoint_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// checkpoint_ctrl_pkg
// Shared types and constants for the branch checkpoint controller:
//   ROB_W        - ROB tag width
//   N_CKPT       - number of checkpoint slots
//   CKPT_W       - slot index width
//   rob_tag_t    - ROB tag
//   ckpt_idx_t   - checkpoint slot index
//   ckpt_state_e - recovery sequencer states
//   ckpt_entry_t - per-slot bookkeeping (valid + owning ROB tag)
//   rob_age()    - distance of a tag from the ROB head (mod 2^ROB_W)
// -----------------------------------------------------------------------------
package checkpoint_ctrl_pkg;

  localparam int ROB_W  = 4;
  localparam int N_CKPT = 4;
  localparam int CKPT_W = $clog2(N_CKPT);

  typedef logic [ROB_W-1:0]  rob_tag_t;
  typedef logic [CKPT_W-1:0] ckpt_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    RESUME  = 2'd2
  } ckpt_state_e;

  typedef struct packed {
    logic     valid;
    rob_tag_t rob_tag;
  } ckpt_entry_t;

  // Unsigned subtraction wraps naturally, so tags that straddle the
  // 2^ROB_W boundary still order correctly relative to the head.
  function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
    return rob_tag_t'(tag - head);
  endfunction

endpackage

// File: rtl/checkpoint_ctrl_if.sv
// -----------------------------------------------------------------------------
// checkpoint_ctrl_if
// Handshake bundle between rename/execute and the checkpoint controller.
//   alloc_valid/alloc_rob_tag         - rename requests a slot for a branch
//   alloc_ready/alloc_slot/snap_we    - controller grants a slot, writes snapshot
//   resolve_valid/resolve_rob_tag/
//   resolve_mispredict                - branch resolution from execute
//   resolve_ready                     - controller accepts the resolution
// master: the pipeline side; slave: the checkpoint controller.
// -----------------------------------------------------------------------------
interface checkpoint_ctrl_if;
  import checkpoint_ctrl_pkg::*;

  logic      alloc_valid;
  rob_tag_t  alloc_rob_tag;
  logic      alloc_ready;
  ckpt_idx_t alloc_slot;
  logic      snap_we;

  logic      resolve_valid;
  logic      resolve_ready;
  rob_tag_t  resolve_rob_tag;
  logic      resolve_mispredict;

  modport master (
    output alloc_valid, alloc_rob_tag,
    output resolve_valid, resolve_rob_tag, resolve_mispredict,
    input  alloc_ready, alloc_slot, snap_we, resolve_ready
  );

  modport slave (
    input  alloc_valid, alloc_rob_tag,
    input  resolve_valid, resolve_rob_tag, resolve_mispredict,
    output alloc_ready, alloc_slot, snap_we, resolve_ready
  );

endinterface

// File: rtl/checkpoint_ctrl_age_cmp.sv
// -----------------------------------------------------------------------------
// ckpt_age_cmp
// Combinational program-order compare relative to the ROB head.
//   tag_a, tag_b - ROB tags to compare
//   rob_head     - current ROB head (oldest in-flight entry)
//   a_younger    - 1 when tag_a was renamed after tag_b
// -----------------------------------------------------------------------------
module ckpt_age_cmp
  import checkpoint_ctrl_pkg::*;
(
  input  rob_tag_t tag_a,
  input  rob_tag_t tag_b,
  input  rob_tag_t rob_head,
  output logic     a_younger
);

  rob_tag_t age_a;
  rob_tag_t age_b;

  assign age_a     = rob_age(tag_a, rob_head);
  assign age_b     = rob_age(tag_b, rob_head);
  assign a_younger = (age_a > age_b);

endmodule

// File: rtl/checkpoint_ctrl.sv
// -----------------------------------------------------------------------------
// checkpoint_ctrl
// Owns the pool of branch checkpoint slots. Allocates a slot per renamed
// branch (and drives the external snapshot write), frees it on correct
// resolution, and on a mispredict frees it plus every younger slot and
// sequences a one-cycle restore pulse with a two-cycle rename stall.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   bus (slave)      - alloc / resolve handshakes (see checkpoint_ctrl_if)
//   rob_head         - ROB head tag for age comparisons
//   restore_en       - pulse: restore snapshot from restore_slot
//   restore_slot     - slot of the mispredicted branch
//   restore_rob_tag  - tag of the mispredicted branch
//   rename_stall     - hold the rename frontend during recovery
//   ckpt_valid       - slot occupancy vector
//   err_bad_tag      - sticky: duplicate alloc tag or resolve tag miss
// -----------------------------------------------------------------------------
module checkpoint_ctrl
  import checkpoint_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  checkpoint_ctrl_if.slave  bus,
  input  rob_tag_t          rob_head,
  output logic              restore_en,
  output ckpt_idx_t         restore_slot,
  output rob_tag_t          restore_rob_tag,
  output logic              rename_stall,
  output logic [N_CKPT-1:0] ckpt_valid,
  output logic              err_bad_tag
);

  ckpt_state_e state_q, state_d;
  ckpt_entry_t slot_q [N_CKPT];
  ckpt_entry_t slot_d [N_CKPT];
  ckpt_idx_t   restore_slot_q, restore_slot_d;
  rob_tag_t    restore_tag_q, restore_tag_d;
  logic        err_q, err_d;

  logic [N_CKPT-1:0] alloc_hit;
  logic [N_CKPT-1:0] res_hit;
  logic [N_CKPT-1:0] younger;
  logic              free_any;
  logic              res_hit_any;
  logic              alloc_dup;
  ckpt_idx_t         free_idx;
  ckpt_idx_t         res_idx;
  logic              idle;
  logic              res_fire;
  logic              mp_fire;
  logic              alloc_fire;

  // Per-slot tag matches and age compare against the resolving branch.
  for (genvar gi = 0; gi < N_CKPT; gi++) begin : g_slot
    assign ckpt_valid[gi] = slot_q[gi].valid;
    assign alloc_hit[gi]  = slot_q[gi].valid && (slot_q[gi].rob_tag == bus.alloc_rob_tag);
    assign res_hit[gi]    = slot_q[gi].valid && (slot_q[gi].rob_tag == bus.resolve_rob_tag);

    ckpt_age_cmp u_age_cmp (
      .tag_a     (slot_q[gi].rob_tag),
      .tag_b     (bus.resolve_rob_tag),
      .rob_head  (rob_head),
      .a_younger (younger[gi])
    );
  end

  assign free_any    = ~&ckpt_valid;
  assign res_hit_any = |res_hit;
  assign alloc_dup   = |alloc_hit;

  // Lowest-indexed free slot, from registered state only: a slot freed this
  // cycle is not handed out until the next cycle.
  always_comb begin
    free_idx = '0;
    for (int i = N_CKPT - 1; i >= 0; i--) begin
      if (!slot_q[i].valid) free_idx = ckpt_idx_t'(i);
    end
  end

  always_comb begin
    res_idx = '0;
    for (int i = N_CKPT - 1; i >= 0; i--) begin
      if (res_hit[i]) res_idx = ckpt_idx_t'(i);
    end
  end

  // Readies are gated by rst_n so every output reads 0 while reset is held.
  assign idle              = (state_q == IDLE);
  assign bus.alloc_ready   = rst_n & idle & free_any;
  assign bus.resolve_ready = rst_n & idle;
  assign res_fire          = bus.resolve_valid & bus.resolve_ready;
  assign mp_fire           = res_fire & bus.resolve_mispredict & res_hit_any;
  // A branch renamed in the mispredict cycle is younger and gets flushed,
  // so its checkpoint is never written.
  assign alloc_fire        = bus.alloc_valid & bus.alloc_ready & ~mp_fire;
  assign bus.alloc_slot    = free_idx;
  assign bus.snap_we       = alloc_fire;

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    restore_slot_d = restore_slot_q;
    restore_tag_d  = restore_tag_q;
    err_d          = err_q;

    case (state_q)
      IDLE:    if (mp_fire) state_d = RESTORE;
      RESTORE: state_d = RESUME;
      RESUME:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < N_CKPT; i++) begin
      if (res_fire && res_hit[i]) slot_d[i].valid = 1'b0;
      if (mp_fire && slot_q[i].valid && younger[i]) slot_d[i].valid = 1'b0;
      // The granted slot is free in slot_q, so it never collides with a
      // slot being cleared above.
      if (alloc_fire && (free_idx == ckpt_idx_t'(i))) begin
        slot_d[i].valid   = 1'b1;
        slot_d[i].rob_tag = bus.alloc_rob_tag;
      end
    end

    if (mp_fire) begin
      restore_slot_d = res_idx;
      restore_tag_d  = bus.resolve_rob_tag;
    end

    if ((alloc_fire && alloc_dup) || (res_fire && !res_hit_any)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      restore_slot_q <= '0;
      restore_tag_q  <= '0;
      err_q          <= 1'b0;
      for (int i = 0; i < N_CKPT; i++) slot_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      restore_slot_q <= restore_slot_d;
      restore_tag_q  <= restore_tag_d;
      err_q          <= err_d;
      for (int i = 0; i < N_CKPT; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign restore_en      = (state_q == RESTORE);
  assign rename_stall    = (state_q != IDLE);
  assign restore_slot    = restore_slot_q;
  assign restore_rob_tag = restore_tag_q;
  assign err_bad_tag     = err_q;

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// -----------------------------------------------------------------------------
// tb_checkpoint_ctrl
// Directed bench for checkpoint_ctrl: allocation order, full pool, correct
// resolve with concurrent alloc, mispredict flush and restore sequencing,
// tag wrap-around, bad-tag error flag, and reset during RESTORE.
// -----------------------------------------------------------------------------
module tb_checkpoint_ctrl;
  import checkpoint_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  rob_tag_t          rob_head;
  logic              restore_en;
  ckpt_idx_t         restore_slot;
  rob_tag_t          restore_rob_tag;
  logic              rename_stall;
  logic [N_CKPT-1:0] ckpt_valid;
  logic              err_bad_tag;

  int n_tests = 0;
  int n_fail  = 0;

  checkpoint_ctrl_if bus ();

  checkpoint_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .rob_head        (rob_head),
    .restore_en      (restore_en),
    .restore_slot    (restore_slot),
    .restore_rob_tag (restore_rob_tag),
    .rename_stall    (rename_stall),
    .ckpt_valid      (ckpt_valid),
    .err_bad_tag     (err_bad_tag)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one set of request inputs and let combinational outputs settle.
  task automatic drive(input logic av, input rob_tag_t at, input logic rv,
                       input rob_tag_t rt, input logic mp);
    bus.alloc_valid        = av;
    bus.alloc_rob_tag      = at;
    bus.resolve_valid      = rv;
    bus.resolve_rob_tag    = rt;
    bus.resolve_mispredict = mp;
    #1;
  endtask

  initial begin
    rob_tag_t wrap_tags [3];
    wrap_tags[0] = 4'd15;
    wrap_tags[1] = 4'd0;
    wrap_tags[2] = 4'd1;

    rst_n    = 1'b0;
    rob_head = 4'd0;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    #2;
    check_val("rst_alloc_ready", bus.alloc_ready, 0);
    check_val("rst_resolve_ready", bus.resolve_ready, 0);
    check_val("rst_restore_en", restore_en, 0);
    check_val("rst_rename_stall", rename_stall, 0);
    check_val("rst_ckpt_valid", ckpt_valid, 0);
    check_val("rst_err", err_bad_tag, 0);
    $display("[TB] reset held");

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_alloc_ready", bus.alloc_ready, 1);
    check_val("post_rst_resolve_ready", bus.resolve_ready, 1);
    tick();

    // Fill the pool with tags 2..5.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rob_tag_t'(2 + i), 1'b0, 4'd0, 1'b0);
      check_val("fill_ready", bus.alloc_ready, 1);
      check_val("fill_slot", bus.alloc_slot, i);
      check_val("fill_snap_we", bus.snap_we, 1);
      $display("[TB] alloc tag=%0d slot=%0d", 2 + i, bus.alloc_slot);
      tick();
    end
    drive(1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
    check_val("full_valid", ckpt_valid, 4'b1111);
    check_val("full_alloc_ready", bus.alloc_ready, 0);
    check_val("full_snap_we", bus.snap_we, 0);
    check_val("full_rename_stall", rename_stall, 0);
    $display("[TB] alloc tag=6 blocked, pool full");

    // Correct resolve of tag 3 while tag 6 waits; tag 6 lands in slot 1 next cycle.
    drive(1'b1, 4'd6, 1'b1, 4'd3, 1'b0);
    check_val("res3_resolve_ready", bus.resolve_ready, 1);
    check_val("res3_snap_we", bus.snap_we, 0);
    tick();
    check_val("res3_valid", ckpt_valid, 4'b1101);
    $display("[TB] resolve tag=3 correct");
    drive(1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
    check_val("alloc6_ready", bus.alloc_ready, 1);
    check_val("alloc6_slot", bus.alloc_slot, 1);
    check_val("alloc6_snap_we", bus.snap_we, 1);
    tick();
    check_val("alloc6_valid", ckpt_valid, 4'b1111);
    $display("[TB] alloc tag=6 slot=1");

    // Swap tag 6 back for tag 3 in slot 1.
    drive(1'b0, 4'd0, 1'b1, 4'd6, 1'b0);
    tick();
    check_val("res6_valid", ckpt_valid, 4'b1101);
    drive(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
    check_val("realloc3_slot", bus.alloc_slot, 1);
    tick();
    check_val("realloc3_valid", ckpt_valid, 4'b1111);
    $display("[TB] swap tag 6 -> tag 3 in slot 1");

    // Mispredict tag 3 with a concurrent alloc of tag 6.
    drive(1'b1, 4'd6, 1'b1, 4'd3, 1'b1);
    check_val("mp3_snap_we", bus.snap_we, 0);
    check_val("mp3_restore_en_early", restore_en, 0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    check_val("mp3_valid", ckpt_valid, 4'b0001);
    check_val("mp3_restore_en", restore_en, 1);
    check_val("mp3_restore_slot", restore_slot, 1);
    check_val("mp3_restore_tag", restore_rob_tag, 3);
    check_val("mp3_stall1", rename_stall, 1);
    check_val("mp3_alloc_ready", bus.alloc_ready, 0);
    check_val("mp3_resolve_ready", bus.resolve_ready, 0);
    tick();
    check_val("mp3_restore_en_off", restore_en, 0);
    check_val("mp3_stall2", rename_stall, 1);
    tick();
    check_val("mp3_stall_release", rename_stall, 0);
    check_val("mp3_alloc_ready_back", bus.alloc_ready, 1);
    check_val("mp3_valid_after", ckpt_valid, 4'b0001);
    check_val("mp3_restore_slot_hold", restore_slot, 1);
    $display("[TB] mispredict tag=3 restore_slot=1 flushed younger");

    // Wrap-around: head 14, live tags 15,0,1; mispredict 15 flushes all.
    drive(1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
    tick();
    check_val("wrap_clear", ckpt_valid, 4'b0000);
    rob_head = 4'd14;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, wrap_tags[i], 1'b0, 4'd0, 1'b0);
      check_val("wrap_alloc_slot", bus.alloc_slot, i);
      $display("[TB] alloc tag=%0d slot=%0d", wrap_tags[i], bus.alloc_slot);
      tick();
    end
    check_val("wrap_valid", ckpt_valid, 4'b0111);
    drive(1'b1, 4'd7, 1'b1, 4'd15, 1'b1);
    check_val("wrap_alloc_ready", bus.alloc_ready, 1);
    check_val("wrap_snap_we_drop", bus.snap_we, 0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    check_val("wrap_flush", ckpt_valid, 4'b0000);
    check_val("wrap_restore_en", restore_en, 1);
    check_val("wrap_restore_slot", restore_slot, 0);
    check_val("wrap_restore_tag", restore_rob_tag, 15);
    tick();
    tick();
    check_val("wrap_stall_release", rename_stall, 0);
    check_val("wrap_valid_after", ckpt_valid, 4'b0000);
    check_val("wrap_err_clean", err_bad_tag, 0);
    $display("[TB] mispredict tag=15 across wrap flushed tags 0,1");

    // Resolve of an unallocated tag raises the sticky error.
    drive(1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
    check_val("bad_alloc4_slot", bus.alloc_slot, 0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 4'd9, 1'b0);
    check_val("bad_resolve_ready", bus.resolve_ready, 1);
    tick();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    check_val("bad_valid", ckpt_valid, 4'b0001);
    check_val("bad_err", err_bad_tag, 1);
    check_val("bad_no_restore", rename_stall, 0);
    tick();
    tick();
    check_val("bad_err_sticky", err_bad_tag, 1);
    $display("[TB] resolve tag=9 miss -> err_bad_tag");

    // Reset asserted during RESTORE.
    drive(1'b0, 4'd0, 1'b1, 4'd4, 1'b1);
    tick();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    check_val("rr_restore_en", restore_en, 1);
    rst_n = 1'b0;
    #1;
    check_val("rr_restore_en_off", restore_en, 0);
    check_val("rr_stall_off", rename_stall, 0);
    check_val("rr_valid", ckpt_valid, 4'b0000);
    check_val("rr_err", err_bad_tag, 0);
    check_val("rr_restore_tag", restore_rob_tag, 0);
    check_val("rr_alloc_ready", bus.alloc_ready, 0);
    check_val("rr_resolve_ready", bus.resolve_ready, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("rr_post_restore_en", restore_en, 0);
      check_val("rr_post_stall", rename_stall, 0);
      check_val("rr_post_valid", ckpt_valid, 4'b0000);
      check_val("rr_post_alloc_ready", bus.alloc_ready, 1);
      @(negedge clk);
    end
    $display("[TB] reset during RESTORE, no pulse afterwards");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/checkpoint_ctrl.md
Name: checkpoint_ctrl

Overview:
Manages the small pool of branch checkpoint slots used for Phase 4 recovery. The snapshot storage itself (RAT, free list and PRF-valid snapshots) lives outside this block; this block only drives it.
- At rename: allocates a slot per branch/jump, keyed by ROB tag, and drives the snapshot write.
- On correct resolution: frees that slot.
- On mispredict: frees the slot and every younger slot, then sequences a restore pulse and a rename stall.

Parameters:
- N_CKPT, 4, number of checkpoint slots.
- CKPT_W, $clog2(N_CKPT), slot index width.
- ROB_W, package ROB_W (4), ROB tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  renamed branch requests a checkpoint.
- alloc_rob_tag  in  ROB_W  ROB tag of that branch.
- alloc_ready  out  1  a slot can be granted this cycle.
- alloc_slot  out  CKPT_W  slot granted; valid when alloc_valid & alloc_ready.
- snap_we  out  1  write snapshot into alloc_slot this cycle.
- resolve_valid  in  1  branch resolution presented.
- resolve_ready  out  1  resolution accepted this cycle.
- resolve_rob_tag  in  ROB_W  tag of the resolving branch.
- resolve_mispredict  in  1  1 = mispredicted.
- rob_head  in  ROB_W  current ROB head, used for age compare.
- restore_en  out  1  one-cycle pulse: restore from restore_slot.
- restore_slot  out  CKPT_W  slot to restore.
- restore_rob_tag  out  ROB_W  mispredicted branch tag; ROB truncates everything younger.
- rename_stall  out  1  rename frontend must hold.
- ckpt_valid  out  N_CKPT  occupancy vector.
- err_bad_tag  out  1  sticky protocol-error flag.

Behaviour:
- Per-slot state: valid bit and stored rob_tag.
- FSM states: IDLE, RESTORE, RESUME.
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all valid bits=0; all outputs 0.
  - Exception: alloc_ready=1 combinationally once rst_n=1.
- Age: age(t) = (t - rob_head) mod 2^ROB_W. A is younger than B iff age(A) > age(B).
- alloc_ready = (state==IDLE) & (some slot invalid).
- alloc_slot = lowest-indexed invalid slot, computed from registered valid bits. Slots freed in the same cycle are not bypassed.
- Alloc fire = alloc_valid & alloc_ready & !(mispredict fire):
  - snap_we=1 in the same cycle.
  - Slot valid is set and its tag is stored at the clock edge.
- Alloc with a tag already held by a valid slot: the allocation still proceeds and err_bad_tag is set.
- resolve_ready = (state==IDLE). Upstream holds resolve_valid until accepted.
- Correct resolve fire: clear the slot whose tag matches at the clock edge. Alloc and correct resolve in the same cycle both take effect.
- Resolve with no matching valid slot: no state change; err_bad_tag set.
- Mispredict fire (IDLE, resolve_valid, resolve_mispredict, tag hit):
  - Clear the matching slot and all valid slots whose age exceeds the branch's age.
  - Any same-cycle alloc is dropped: snap_we=0. That branch is younger and is flushed.
  - Register restore_slot and restore_rob_tag, then go to RESTORE.
- Mispredict with a tag miss: treated as error; no recovery; stay in IDLE.
- RESTORE (1 cycle): restore_en=1, rename_stall=1, alloc_ready=0, resolve_ready=0. Next state RESUME.
- RESUME (1 cycle): rename_stall=1, restore_en=0. Next state IDLE.
- Latency: restore_en rises exactly 1 cycle after mispredict fire; rename is released 3 cycles after fire.
- Full (all slots valid): alloc_ready=0, rename_stall=0. Upstream stalls on alloc_ready.
- Tag wrap-around is handled by the mod-2^ROB_W age arithmetic. ROB occupancy < 2^ROB_W guarantees unique ages.
- rst_n asserted mid-RESTORE: FSM returns to IDLE immediately; no restore_en pulse is emitted afterward.
- restore_slot and restore_rob_tag hold their values until the next mispredict.

Decomposition:
- Add to checkpoint_types:
  - N_CKPT and CKPT_W constants.
  - ckpt_idx_t.
  - ckpt_state_e enum {IDLE, RESTORE, RESUME}.
  - ckpt_entry_t struct {valid, rob_tag}.
- One natural sub-module, ckpt_age_cmp: combinational younger-than compare relative to rob_head, instantiated per slot.

Test Plan:
- Reset, then allocate tags 2,3,4,5 back-to-back with rob_head=0 -> slots 0,1,2,3 granted; snap_we high each cycle; ckpt_valid=4'b1111; alloc_ready=0 on the 5th request.
- Correct resolve of tag 3 together with alloc of tag 6 in the same cycle -> tag 6 gets slot 0 only if slot 0 was free; otherwise it waits one cycle and gets slot 1; ckpt_valid correct after each edge.
- With tags 2,3,4,5 live, mispredict tag 3 with a simultaneous alloc of tag 6 -> snap_we=0; ckpt_valid keeps only the slot holding tag 2; restore_en pulses next cycle with restore_slot=1, restore_rob_tag=3; rename_stall high for 2 cycles.
- Wrap: rob_head=14, live tags 15,0,1; mispredict tag 15 -> tags 0 and 1 also freed.
- Resolve of an unallocated tag 9 -> no ckpt_valid change; err_bad_tag=1 and stays set.
- rst_n pulled low during RESTORE -> all outputs 0 asynchronously; after release, no restore_en pulse and ckpt_valid=0.
